iq_na_averager: RTL



---
 rtl/iq_na_averager_if.sv | 20 ++
 rtl/iq_na_averager.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/iq_na_averager_if.sv
// PS register bus between processor (master) and averager (slave).
// Ports: addr/wen/ren/wdata from master; ack/rdata from slave.
interface iq_na_averager_if;
  logic [15:0] addr;
  logic        wen;
  logic        ren;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output addr, wen, ren, wdata,
    input  ack, rdata
  );

  modport slave (
    input  addr, wen, ren, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/iq_na_averager.sv
// Multi-channel IQ averager: settle S cycles, sum N samples per channel.
// Ports: clk_i, rstn_i, trig_i, dat_i, busy_o, done_o, bus (register slave).
module iq_na_averager #(
  parameter int CHANNELS = 2,
  parameter int INBITS   = 24,
  parameter int ACCBITS  = 62,
  parameter int CNTBITS  = 32
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       trig_i,
  input  logic [CHANNELS*INBITS-1:0] dat_i,
  output logic                       busy_o,
  output logic                       done_o,
  iq_na_averager_if.slave            bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SLEEP = 2'd1;
  localparam logic [1:0] ST_AVG   = 2'd2;

  logic [1:0]         state_q, state_d;
  logic               cont_q, cont_d;
  logic               trgen_q, trgen_d;
  logic               trig_q;
  logic [CNTBITS-1:0] n_q, n_d;
  logic [CNTBITS-1:0] s_q, s_d;
  logic [CNTBITS-1:0] ncnt_q, ncnt_d;
  logic [CNTBITS-1:0] scnt_q, scnt_d;
  logic [CHANNELS-1:0] ovf_q, ovf_d, ovf_add;
  logic               done_q, done_d;
  logic [15:0]        dcnt_q, dcnt_d;
  logic               ack_q;
  logic [31:0]        rdata_q, rdata_d;

  logic signed [ACCBITS-1:0] acc_q [CHANNELS];
  logic signed [ACCBITS-1:0] acc_d [CHANNELS];
  logic signed [ACCBITS-1:0] res_q [CHANNELS];
  logic signed [ACCBITS-1:0] res_d [CHANNELS];
  logic signed [ACCBITS-1:0] smp   [CHANNELS];
  logic signed [ACCBITS-1:0] sum   [CHANNELS];
  logic        [63:0]        rx    [CHANNELS];

  logic start, restart, fin, fin_sum;

  // Wrapping adders; overflow when operand signs agree but sum differs.
  always_comb begin
    ovf_add = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      smp[k] = ACCBITS'($signed(dat_i[k*INBITS +: INBITS]));
      sum[k] = acc_q[k] + smp[k];
      ovf_add[k] = (acc_q[k][ACCBITS-1] == smp[k][ACCBITS-1]) &&
                   (sum[k][ACCBITS-1] != acc_q[k][ACCBITS-1]);
    end
  end

  assign start = (bus.wen && bus.addr == 16'h0000 && bus.wdata[0]) ||
                 (trig_i && !trig_q && trgen_q);

  // Continuous mode re-arms from the completion cycle like a start.
  assign restart = start || (done_q && cont_q);

  always_comb begin
    state_d = state_q;
    cont_d  = cont_q;
    trgen_d = trgen_q;
    n_d     = n_q;
    s_d     = s_q;
    ncnt_d  = ncnt_q;
    scnt_d  = scnt_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    dcnt_d  = dcnt_q;
    acc_d   = acc_q;
    res_d   = res_q;
    fin     = 1'b0;
    fin_sum = 1'b0;

    if (bus.wen) begin
      case (bus.addr)
        16'h0000: begin
          cont_d  = bus.wdata[1];
          trgen_d = bus.wdata[2];
        end
        16'h0004: n_d = CNTBITS'(bus.wdata);
        16'h0008: s_d = CNTBITS'(bus.wdata);
        default: ;
      endcase
    end

    if (restart) begin
      for (int k = 0; k < CHANNELS; k++) acc_d[k] = '0;
      ovf_d  = '0;
      ncnt_d = n_q;
      scnt_d = s_q;
      if (s_q != '0)      state_d = ST_SLEEP;
      else if (n_q != '0) state_d = ST_AVG;
      else                fin     = 1'b1;
    end else begin
      unique case (state_q)
        ST_SLEEP: begin
          if (scnt_q == CNTBITS'(1)) begin
            if (ncnt_q != '0) state_d = ST_AVG;
            else              fin     = 1'b1;
          end else begin
            scnt_d = scnt_q - CNTBITS'(1);
          end
        end
        ST_AVG: begin
          acc_d = sum;
          ovf_d = ovf_q | ovf_add;
          if (ncnt_q == CNTBITS'(1)) begin
            fin     = 1'b1;
            fin_sum = 1'b1;
          end else begin
            ncnt_d = ncnt_q - CNTBITS'(1);
          end
        end
        default: ;
      endcase
    end

    // N=0 completes with the freshly cleared (zero) sums.
    if (fin) begin
      state_d = ST_IDLE;
      done_d  = 1'b1;
      dcnt_d  = dcnt_q + 16'd1;
      for (int k = 0; k < CHANNELS; k++)
        res_d[k] = fin_sum ? sum[k] : '0;
    end
  end

  always_comb begin
    for (int k = 0; k < CHANNELS; k++) rx[k] = 64'(res_q[k]);
  end

  always_comb begin
    rdata_d = '0;
    if (bus.ren) begin
      case (bus.addr)
        16'h0000: rdata_d = {29'd0, trgen_q, cont_q, 1'b0};
        16'h0004: rdata_d = 32'(n_q);
        16'h0008: rdata_d = 32'(s_q);
        16'h000C: rdata_d = {dcnt_q, 8'(ovf_q), 6'd0, state_q};
        16'h0200: rdata_d = 32'(CHANNELS);
        16'h0204: rdata_d = 32'(INBITS);
        16'h0208: rdata_d = 32'(ACCBITS);
        default: ;
      endcase
      for (int k = 0; k < CHANNELS; k++) begin
        if (bus.addr == 16'(64 + 8*k)) rdata_d = rx[k][31:0];
        if (bus.addr == 16'(68 + 8*k)) rdata_d = rx[k][63:32];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      cont_q  <= 1'b0;
      trgen_q <= 1'b0;
      trig_q  <= 1'b0;
      n_q     <= '0;
      s_q     <= '0;
      ncnt_q  <= '0;
      scnt_q  <= '0;
      ovf_q   <= '0;
      done_q  <= 1'b0;
      dcnt_q  <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        acc_q[k] <= '0;
        res_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      cont_q  <= cont_d;
      trgen_q <= trgen_d;
      trig_q  <= trig_i;
      n_q     <= n_d;
      s_q     <= s_d;
      ncnt_q  <= ncnt_d;
      scnt_q  <= scnt_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      dcnt_q  <= dcnt_d;
      ack_q   <= bus.wen | bus.ren;
      rdata_q <= rdata_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

  assign busy_o    = (state_q == ST_SLEEP) || (state_q == ST_AVG);
  assign done_o    = done_q;
  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;

endmodule
